evt_framer: RTL and testbench

Downstream stage of the event packer. It pops 32-bit packed words and their end-of-event flag from the packer's output FIFO and wraps each event in a header word and a trailer word. The framed stream goes to the readout sink (USB/host FIFO) over a valid/ready handshake. It carries the standard 16-bit register port for control, status and counters.

---
 rtl/evt_pkg.sv | 28 ++
 rtl/evt_framer.sv | 140 ++++++++++++++
 tb/tb_evt_framer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/evt_pkg.sv
// Shared definitions for the event framer: register map, command codes, FSM encoding and default tags.
package evt_pkg;

  localparam logic [7:0] REGADDR_STATUS = 8'h00;
  localparam logic [7:0] REGADDR_CTRL   = 8'h01;
  localparam logic [7:0] REGADDR_CMD    = 8'h02;
  localparam logic [7:0] REGADDR_NEV    = 8'h03;
  localparam logic [7:0] REGADDR_NOUT   = 8'h04;

  localparam logic [15:0] CMD_RST = 16'h0000;
  localparam logic [15:0] CMD_CLR = 16'h0001;

  localparam logic [15:0] REG_UNMAPPED = 16'hF001;

  localparam logic [7:0] DEF_HDR_TAG = 8'hA5;
  localparam logic [7:0] DEF_TRL_TAG = 8'h5A;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_TRAILER = 2'd2
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/evt_framer.sv
// Wraps each packer event in a header and trailer word; one-cycle latency through a registered output slot.
// Pops upstream only when the output slot is free, so sink backpressure stalls the packer FIFO directly.
module evt_framer
  import evt_pkg::*;
#(
  parameter logic [7:0] HDR_TAG = DEF_HDR_TAG,
  parameter logic [7:0] TRL_TAG = DEF_TRL_TAG
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        reg_we_i,
  input  logic [7:0]  reg_addr_i,
  input  logic [15:0] reg_data_i,
  output logic [15:0] reg_data_o,
  input  logic [31:0] data_i,
  input  logic        evtdone_i,
  input  logic        empty_i,
  output logic        re_o,
  output logic [31:0] data_o,
  output logic        valid_o,
  output logic        last_o,
  input  logic        ready_i
);

  state_t      r_state;
  logic [31:0] r_data;
  logic        r_vld;
  logic        r_last;
  logic        r_en;
  logic [15:0] r_evt_id;
  logic [15:0] r_wcnt;
  logic [15:0] r_nev;
  logic [15:0] r_nout;

  logic        w_slot_free;
  logic        w_re;
  logic        w_ld_trl;
  logic        w_cmd_rst;
  logic        w_cmd_clr;
  logic        w_ctrl_we;
  logic [15:0] w_status;

  assign w_slot_free = !r_vld || ready_i;
  assign w_re        = (r_state == ST_PAYLOAD) && !empty_i && w_slot_free;
  assign w_ld_trl    = (r_state == ST_TRAILER) && w_slot_free;
  assign w_cmd_rst   = reg_we_i && (reg_addr_i == REGADDR_CMD) && (reg_data_i == CMD_RST);
  assign w_cmd_clr   = reg_we_i && (reg_addr_i == REGADDR_CMD) && (reg_data_i == CMD_CLR);
  assign w_ctrl_we   = reg_we_i && (reg_addr_i == REGADDR_CTRL);
  assign w_status    = {r_state, 11'b0, r_en, r_vld, empty_i};

  assign re_o    = w_re;
  assign data_o  = r_data;
  assign valid_o = r_vld;
  assign last_o  = r_last;

  always_comb begin
    reg_data_o = REG_UNMAPPED;
    case (reg_addr_i)
      REGADDR_STATUS, REGADDR_CMD: reg_data_o = w_status;
      REGADDR_CTRL:                reg_data_o = {15'b0, r_en};
      REGADDR_NEV:                 reg_data_o = r_nev;
      REGADDR_NOUT:                reg_data_o = r_nout;
      default:                     reg_data_o = REG_UNMAPPED;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_data   <= '0;
      r_vld    <= 1'b0;
      r_last   <= 1'b0;
      r_en     <= 1'b0;
      r_evt_id <= '0;
      r_wcnt   <= '0;
      r_nev    <= '0;
      r_nout   <= '0;
    end else if (w_cmd_rst) begin
      // Abandons any open event; its remaining words stay in the packer FIFO.
      r_state  <= ST_IDLE;
      r_data   <= '0;
      r_vld    <= 1'b0;
      r_last   <= 1'b0;
      r_en     <= 1'b0;
      r_evt_id <= '0;
      r_wcnt   <= '0;
      r_nev    <= '0;
      r_nout   <= '0;
    end else begin
      if (w_ctrl_we)
        r_en <= reg_data_i[0];

      if (w_cmd_clr)
        r_nout <= '0;
      else if (r_vld && ready_i)
        r_nout <= r_nout + 16'd1;

      if (w_cmd_clr)
        r_nev <= '0;
      else if (w_ld_trl)
        r_nev <= r_nev + 16'd1;

      if (w_slot_free) begin
        r_vld  <= 1'b0;
        r_last <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (r_en && !empty_i && w_slot_free) begin
            r_data  <= {HDR_TAG, 8'h00, r_evt_id};
            r_vld   <= 1'b1;
            r_wcnt  <= '0;
            r_state <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (w_re) begin
            r_data <= data_i;
            r_vld  <= 1'b1;
            r_wcnt <= sat_inc16(r_wcnt);
            if (evtdone_i)
              r_state <= ST_TRAILER;
          end
        end
        ST_TRAILER: begin
          if (w_ld_trl) begin
            r_data   <= {TRL_TAG, 8'h00, r_wcnt};
            r_vld    <= 1'b1;
            r_last   <= 1'b1;
            r_evt_id <= r_evt_id + 16'd1;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_evt_framer.sv
// Bench for evt_framer: queue-based packer FIFO and framing model, scoreboard monitor on the sink side.
module tb_evt_framer;
  import evt_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        reg_we_i = 1'b0;
  logic [7:0]  reg_addr_i = 8'h00;
  logic [15:0] reg_data_i = 16'h0000;
  logic [15:0] reg_data_o;
  logic [31:0] data_i = 32'h0;
  logic        evtdone_i = 1'b0;
  logic        empty_i = 1'b1;
  logic        re_o;
  logic [31:0] data_o;
  logic        valid_o;
  logic        last_o;
  logic        ready_i = 1'b0;

  evt_framer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .reg_we_i(reg_we_i), .reg_addr_i(reg_addr_i), .reg_data_i(reg_data_i), .reg_data_o(reg_data_o),
    .data_i(data_i), .evtdone_i(evtdone_i), .empty_i(empty_i), .re_o(re_o),
    .data_o(data_o), .valid_o(valid_o), .last_o(last_o), .ready_i(ready_i)
  );

  always #5 clk_i = ~clk_i;

  logic [31:0] fifo_dat[$];
  logic        fifo_eod[$];
  logic [32:0] exp_q[$];
  int          acc_cyc[$];

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_pops = 0;
  int          acc_cnt = 0;
  int          nev_mdl = 0;
  int          rdy_mode = 0;
  logic        pop_pending = 1'b0;
  logic [15:0] mdl_id = 16'h0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_dat = 32'h0;
  logic        prev_last = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Sink-side monitor: one comparison per accepted word, plus protocol checks.
  always @(negedge clk_i) begin
    logic [32:0] e;
    if (!rst_i) begin
      pop_pending = re_o;
      if (re_o) begin
        n_tests++;
        if (valid_o && !ready_i) begin
          n_fail++;
          $display("FAIL re_slot: re_o=1 with valid_o=1 ready_i=0");
        end
      end
      if (prev_stall) begin
        n_tests++;
        if (!valid_o || data_o !== prev_dat || last_o !== prev_last) begin
          n_fail++;
          $display("FAIL hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                   valid_o, data_o, last_o, prev_dat, prev_last);
        end
      end
      prev_stall = valid_o && !ready_i &&
                   !(reg_we_i && reg_addr_i == REGADDR_CMD && reg_data_i == CMD_RST);
      prev_dat  = data_o;
      prev_last = last_o;
      if (valid_o && ready_i) begin
        acc_cyc.push_back(cyc);
        acc_cnt++;
        if (last_o) nev_mdl++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got %h last=%b expected none", data_o, last_o);
        end else begin
          e = exp_q.pop_front();
          chk("word", {last_o, data_o}, e);
        end
      end
    end
  end

  task automatic drv();
    empty_i   = (fifo_dat.size() == 0);
    data_i    = empty_i ? 32'h0 : fifo_dat[0];
    evtdone_i = empty_i ? 1'b0 : fifo_eod[0];
  endtask

  task automatic cycle();
    @(posedge clk_i);
    #1;
    if (pop_pending) begin
      if (fifo_dat.size() > 0) begin
        void'(fifo_dat.pop_front());
        void'(fifo_eod.pop_front());
        n_pops++;
      end
      pop_pending = 1'b0;
    end
    if (rdy_mode == 1) ready_i = 1'($urandom_range(0, 1));
    else if (rdy_mode == 2) ready_i = ~ready_i;
    drv();
  endtask

  // Model of one framed event: header with running id, payload, trailer with saturated count.
  task automatic push_event(input int n);
    logic [31:0] d;
    exp_q.push_back({1'b0, 8'hA5, 8'h00, mdl_id});
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      fifo_dat.push_back(d);
      fifo_eod.push_back(i == n - 1);
      exp_q.push_back({1'b0, d});
    end
    exp_q.push_back({1'b1, 8'h5A, 8'h00, (n > 65535) ? 16'hFFFF : 16'(n)});
    mdl_id++;
    drv();
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    reg_we_i   = 1'b1;
    reg_addr_i = a;
    reg_data_i = d;
    cycle();
    reg_we_i = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [15:0] v);
    reg_addr_i = a;
    #1;
    v = reg_data_o;
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || fifo_dat.size() != 0) && k < budget) begin
      cycle();
      k++;
    end
    n_tests++;
    if (exp_q.size() != 0 || fifo_dat.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d words outstanding expected 0", name, exp_q.size());
    end
  endtask

  task automatic chk_cnts(input string name);
    logic [15:0] v;
    rd(REGADDR_NEV, v);
    chk({name, "_nev"}, 33'(v), 33'(nev_mdl[15:0]));
    rd(REGADDR_NOUT, v);
    chk({name, "_nout"}, 33'(v), 33'(acc_cnt[15:0]));
  endtask

  initial begin
    logic [15:0] v;
    int k;
    int base;

    drv();
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid", 33'(valid_o), 33'd0);
    chk("rst_data", 33'(data_o), 33'd0);
    chk("rst_last", 33'(last_o), 33'd0);
    rd(REGADDR_STATUS, v);
    chk("rst_status", 33'(v), 33'h0001);
    rst_i = 1'b0;
    rd(REGADDR_CTRL, v);   chk("rst_ctrl", 33'(v), 33'h0000);
    rd(REGADDR_NEV, v);    chk("rst_nev", 33'(v), 33'h0000);
    rd(REGADDR_NOUT, v);   chk("rst_nout", 33'(v), 33'h0000);
    rd(8'h07, v);          chk("unmapped", 33'(v), 33'h0F001);
    rd(REGADDR_CMD, v);    chk("cmd_read", 33'(v), 33'h0001);

    // Single 3-word event, sink always ready.
    ready_i = 1'b1;
    wr(REGADDR_CTRL, 16'h0001);
    rd(REGADDR_CTRL, v);   chk("ctrl_en", 33'(v), 33'h0001);
    acc_cyc.delete();
    push_event(3);
    drain("t1", 50);
    chk("t1_words", 33'(acc_cyc.size()), 33'd5);
    if (acc_cyc.size() == 5) chk("t1_span", 33'(acc_cyc[4] - acc_cyc[0]), 33'd4);
    chk_cnts("t1");

    // Two back-to-back 1-word events.
    acc_cyc.delete();
    push_event(1);
    push_event(1);
    drain("t2", 50);
    chk("t2_words", 33'(acc_cyc.size()), 33'd6);
    if (acc_cyc.size() == 6) chk("t2_span", 33'(acc_cyc[5] - acc_cyc[0]), 33'd5);

    // Alternating ready during a 4-word event.
    rdy_mode = 2;
    push_event(4);
    drain("t3", 60);
    rdy_mode = 0;
    ready_i = 1'b1;
    chk_cnts("t3");

    // en dropped while an event is open: it completes, the next one waits.
    push_event(4);
    push_event(2);
    base = n_pops;
    k = 0;
    while (n_pops == base && k < 20) begin cycle(); k++; end
    chk("t4_started", 33'(n_pops != base), 33'd1);
    wr(REGADDR_CTRL, 16'h0000);
    repeat (20) cycle();
    chk("t4_exp_left", 33'(exp_q.size()), 33'd4);
    chk("t4_fifo_left", 33'(fifo_dat.size()), 33'd2);
    chk("t4_idle_valid", 33'(valid_o), 33'd0);
    rd(REGADDR_STATUS, v);
    chk("t4_state", 33'(v[15:14]), 33'd0);
    wr(REGADDR_CTRL, 16'h0001);
    drain("t4", 50);
    chk_cnts("t4");

    // Randomized events under random backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 25; i++) push_event(int'($urandom_range(1, 8)));
    drain("t5", 3000);
    rdy_mode = 0;
    ready_i = 1'b1;
    cycle();
    chk_cnts("t5");

    // CMD RST in the middle of an event.
    push_event(12);
    base = n_pops;
    k = 0;
    while (n_pops < base + 3 && k < 30) begin cycle(); k++; end
    wr(REGADDR_CMD, CMD_RST);
    chk("t6_valid", 33'(valid_o), 33'd0);
    fifo_dat.delete();
    fifo_eod.delete();
    exp_q.delete();
    pop_pending = 1'b0;
    mdl_id = 16'h0;
    acc_cnt = 0;
    nev_mdl = 0;
    drv();
    rd(REGADDR_STATUS, v); chk("t6_status", 33'(v), 33'h0001);
    rd(REGADDR_CTRL, v);   chk("t6_ctrl", 33'(v), 33'h0000);
    rd(REGADDR_NEV, v);    chk("t6_nev", 33'(v), 33'h0000);
    rd(REGADDR_NOUT, v);   chk("t6_nout", 33'(v), 33'h0000);

    // CMD CLR on the cycle the trailer is loaded.
    wr(REGADDR_CTRL, 16'h0001);
    push_event(2);
    k = 0;
    v = 16'h0;
    while (k < 30) begin
      rd(REGADDR_STATUS, v);
      if (v[15:14] == 2'd2) break;
      cycle();
      k++;
    end
    chk("t7_trailer_state", 33'(v[15:14]), 33'd2);
    ready_i = 1'b0;
    cycle();
    cycle();
    ready_i = 1'b1;
    wr(REGADDR_CMD, CMD_CLR);
    ready_i = 1'b0;
    acc_cnt = 0;
    rd(REGADDR_NEV, v);    chk("t7_nev", 33'(v), 33'h0000);
    rd(REGADDR_NOUT, v);   chk("t7_nout", 33'(v), 33'h0000);
    chk("t7_trl_valid", 33'({valid_o, last_o}), 33'd3);
    ready_i = 1'b1;
    drain("t7", 20);
    rd(REGADDR_NEV, v);    chk("t7_nev_after", 33'(v), 33'h0000);
    rd(REGADDR_NOUT, v);   chk("t7_nout_after", 33'(v), 33'(acc_cnt[15:0]));
    nev_mdl = 0;

    // Oversized event: word count saturates in the trailer.
    push_event(65537);
    drain("t8", 70000);
    chk_cnts("t8");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
